// File: rtl/mem_access_ctrl_pkg.sv
// Shared MEM-stage definitions: FSM encoding, default widths and small helpers.
package mem_stage_pkg;

    localparam int unsigned DATA_W_DEF  = 16;
    localparam int unsigned TMO_CYC_DEF = 64;
    localparam int unsigned CNT_W_DEF   = 16;

    // Two-state access FSM; kept as plain constants so older tools can read it.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // Byte addresses with bit 0 set cannot be served by the halfword-wide cache.
    function automatic logic addr_unaligned(input logic addr_lsb);
        return addr_lsb;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// EX/MEM-to-cache bus bundle seen by the MEM-stage access controller.
interface mem_access_ctrl_if #(
    parameter int DATA_W = 16
);
    // EX/MEM pipeline register side
    logic [DATA_W-1:0] alu_result_in;
    logic [DATA_W-1:0] wdata_in;
    logic              mem_read_in;
    logic              mem_write_in;
    logic              halt_in;
    // data cache side
    logic              dmem_done;
    logic              dmem_hit;
    logic [DATA_W-1:0] dmem_rdata;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_rd;
    logic              dmem_wr;
    // MEM/WB and hazard side
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_stall;
    logic              mem_err;

    // The controller consumes pipeline/cache inputs and drives the bus.
    modport slave (
        input  alu_result_in, wdata_in, mem_read_in, mem_write_in, halt_in,
        input  dmem_done, dmem_hit, dmem_rdata,
        output dmem_addr, dmem_wdata, dmem_rd, dmem_wr,
        output mem_rdata, mem_stall, mem_err
    );

    // The surrounding pipeline/cache environment.
    modport master (
        output alu_result_in, wdata_in, mem_read_in, mem_write_in, halt_in,
        output dmem_done, dmem_hit, dmem_rdata,
        input  dmem_addr, dmem_wdata, dmem_rd, dmem_wr,
        input  mem_rdata, mem_stall, mem_err
    );

endinterface

// File: rtl/mem_access_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {W{1'b0}};
        end else if (inc && (cnt_q != ALL_ONES)) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register, cleared asynchronously with the pipeline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: one cache access per load/store,
// pipeline stall until done, load-data capture, sticky error on misalignment/timeout.
module mem_access_ctrl
    import mem_stage_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TMO_CYC = TMO_CYC_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    mem_access_ctrl_if.slave bus,
    output logic [CNT_W-1:0] acc_cnt,
    output logic [CNT_W-1:0] hit_cnt
);

    localparam int               TMO_W    = $clog2(TMO_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    logic [0:0]        state_d,     state_q;
    logic [DATA_W-1:0] addr_d,      addr_q;
    logic [DATA_W-1:0] wdata_d,     wdata_q;
    logic              is_rd_d,     is_rd_q;
    logic [DATA_W-1:0] mem_rdata_d, mem_rdata_q;
    logic              mem_err_d,   mem_err_q;

    logic              acc_s;
    logic              complete_s;
    logic              complete_rd_s;
    logic              hit_inc_s;
    logic              tmo_clr_s;
    logic              tmo_inc_s;
    logic [TMO_W-1:0]  tmo_q;

    logic [DATA_W-1:0] addr_s;
    logic [DATA_W-1:0] wdata_s;
    logic              rd_s;
    logic              wr_s;
    logic              stall_s;

    // An access is requested by MemRead or MemWrite unless the instruction is HALT.
    assign acc_s = (bus.mem_read_in | bus.mem_write_in) & ~bus.halt_in;

    // FSM next state, launch strobes, latching of address/data, completion and errors.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        is_rd_d       = is_rd_q;
        mem_err_d     = mem_err_q;
        addr_s        = addr_q;
        wdata_s       = wdata_q;
        rd_s          = 1'b0;
        wr_s          = 1'b0;
        stall_s       = 1'b0;
        complete_s    = 1'b0;
        complete_rd_s = 1'b0;
        tmo_clr_s     = 1'b1;
        tmo_inc_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                addr_s  = bus.alu_result_in;
                wdata_s = bus.wdata_in;
                if (acc_s && addr_unaligned(bus.alu_result_in[0])) begin
                    // Misaligned: nothing reaches the cache, the pipeline keeps moving.
                    mem_err_d = 1'b1;
                end else if (acc_s) begin
                    // Read wins when both MemRead and MemWrite are set.
                    rd_s    = bus.mem_read_in;
                    wr_s    = ~bus.mem_read_in;
                    addr_d  = bus.alu_result_in;
                    wdata_d = bus.wdata_in;
                    is_rd_d = bus.mem_read_in;
                    if (bus.dmem_done) begin
                        complete_s    = 1'b1;
                        complete_rd_s = bus.mem_read_in;
                    end else begin
                        stall_s = 1'b1;
                        state_d = ST_WAIT;
                    end
                end else begin
                    // Stray done pulses in IDLE are not ours; ignore them.
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                tmo_clr_s = 1'b0;
                tmo_inc_s = 1'b1;
                if (bus.dmem_done) begin
                    complete_s    = 1'b1;
                    complete_rd_s = is_rd_q;
                    state_d       = ST_IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    // Give up: drop the access, release the pipeline, flag it.
                    mem_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    stall_s = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Load data is captured only on the completing cycle of a read; writes keep the old value.
    always_comb begin
        mem_rdata_d = mem_rdata_q;
        if (complete_rd_s) begin
            mem_rdata_d = bus.dmem_rdata;
        end else begin
            mem_rdata_d = mem_rdata_q;
        end
    end

    // State, latched access and result registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= {DATA_W{1'b0}};
            wdata_q     <= {DATA_W{1'b0}};
            is_rd_q     <= 1'b0;
            mem_rdata_q <= {DATA_W{1'b0}};
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            is_rd_q     <= is_rd_d;
            mem_rdata_q <= mem_rdata_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign hit_inc_s = complete_s & bus.dmem_hit;

    sat_counter #(.W(CNT_W)) u_acc_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (complete_s),
        .q   (acc_cnt)
    );

    sat_counter #(.W(CNT_W)) u_hit_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (hit_inc_s),
        .q   (hit_cnt)
    );

    // Wait-cycle counter: held at zero outside WAIT so each miss starts fresh.
    sat_counter #(.W(TMO_W)) u_tmo_cnt (
        .clk (clk),
        .rst (rst),
        .clr (tmo_clr_s),
        .inc (tmo_inc_s),
        .q   (tmo_q)
    );

    // Drive the bus; combinational outputs are forced low while reset is asserted.
    always_comb begin
        if (!rst) begin
            bus.dmem_addr  = {DATA_W{1'b0}};
            bus.dmem_wdata = {DATA_W{1'b0}};
            bus.dmem_rd    = 1'b0;
            bus.dmem_wr    = 1'b0;
            bus.mem_stall  = 1'b0;
        end else begin
            bus.dmem_addr  = addr_s;
            bus.dmem_wdata = wdata_s;
            bus.dmem_rd    = rd_s;
            bus.dmem_wr    = wr_s;
            bus.mem_stall  = stall_s;
        end
    end

    assign bus.mem_rdata = mem_rdata_q;
    assign bus.mem_err   = mem_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a cache responder and a result scoreboard.
module tb_mem_access_ctrl;

    localparam int TMO = 8;

    typedef struct {
        logic        is_rd;
        logic [15:0] rdata;
        logic        hit;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] acc_cnt;
    logic [3:0] hit_cnt;

    int checks = 0;
    int errors = 0;

    exp_t        sb[$];
    logic [3:0]  m_acc;
    logic [3:0]  m_hit;
    logic [15:0] m_rdata;
    logic        m_err;

    mem_access_ctrl_if #(.DATA_W(16)) bus ();

    mem_access_ctrl #(.DATA_W(16), .TMO_CYC(TMO), .CNT_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .acc_cnt (acc_cnt),
        .hit_cnt (hit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic en);
        return (en && (v != 4'hF)) ? v + 4'd1 : v;
    endfunction

    task automatic idle_inputs();
        bus.mem_read_in   = 1'b0;
        bus.mem_write_in  = 1'b0;
        bus.halt_in       = 1'b0;
        bus.alu_result_in = 16'h0000;
        bus.wdata_in      = 16'h0000;
        bus.dmem_done     = 1'b0;
        bus.dmem_hit      = 1'b0;
        bus.dmem_rdata    = 16'h0000;
    endtask

    // Pop one expected completion and compare results/counters (called at posedge+1).
    task automatic score(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            m_acc = sat_inc(m_acc, 1'b1);
            m_hit = sat_inc(m_hit, e.hit);
            if (e.is_rd) m_rdata = e.rdata;
            chk({tag, "_rdata"}, bus.mem_rdata, m_rdata);
            chk({tag, "_acc"},   acc_cnt,       m_acc);
            chk({tag, "_hit"},   hit_cnt,       m_hit);
            chk({tag, "_err"},   bus.mem_err,   m_err);
        end
    endtask

    // One access; the cache answers lat cycles after launch (0 = same-cycle hit).
    // Entered at posedge+1; returns at posedge+1 of the cycle after completion.
    task automatic do_access(input string tag, input logic rd, input logic [15:0] a,
                             input logic [15:0] d, input int lat, input logic hit,
                             input logic [15:0] rdat);
        exp_t e;
        int stall_n = 0;
        int strobe_n = 0;
        e.is_rd = rd; e.rdata = rdat; e.hit = hit;
        sb.push_back(e);
        bus.mem_read_in   = rd;
        bus.mem_write_in  = ~rd;
        bus.halt_in       = 1'b0;
        bus.alu_result_in = a;
        bus.wdata_in      = d;
        for (int c = 0; c <= lat; c++) begin
            bus.dmem_done  = (c == lat);
            bus.dmem_hit   = (c == lat) ? hit : 1'b0;
            bus.dmem_rdata = (c == lat) ? rdat : 16'hDEAD;
            @(negedge clk);
            if (rd ? bus.dmem_rd : bus.dmem_wr) strobe_n++;
            if (bus.mem_stall) stall_n++;
            if (c == 0) begin
                chk({tag, "_launch_strobe"}, rd ? bus.dmem_rd : bus.dmem_wr, 1'b1);
                chk({tag, "_other_strobe"},  rd ? bus.dmem_wr : bus.dmem_rd, 1'b0);
            end
            chk({tag, "_addr"}, bus.dmem_addr, a);
            if (!rd) chk({tag, "_wdata"}, bus.dmem_wdata, d);
            @(posedge clk); #1;
            // Disturb the frozen EX/MEM inputs; the latched copy must win.
            bus.alu_result_in = a ^ 16'hF0F0;
            bus.wdata_in      = ~d;
        end
        idle_inputs();
        chk({tag, "_strobes"}, strobe_n, 1);
        chk({tag, "_stall_cycles"}, stall_n, lat);
        score(tag);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        m_acc = 4'h0; m_hit = 4'h0; m_rdata = 16'h0000; m_err = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", bus.mem_stall, 1'b0);
        chk("rst_rd",    bus.dmem_rd,   1'b0);
        chk("rst_err",   bus.mem_err,   1'b0);
        chk("rst_acc",   acc_cnt,       4'h0);
        chk("rst_rdata", bus.mem_rdata, 16'h0000);
        rst = 1'b1;
        @(posedge clk); #1;

        // 1. read hit
        do_access("t1_rd_hit", 1'b1, 16'h0010, 16'h0000, 0, 1'b1, 16'hBEEF);
        chk("t1_acc_abs", acc_cnt, 4'd1);
        chk("t1_hit_abs", hit_cnt, 4'd1);

        // 2. write miss, done 5 cycles after launch
        do_access("t2_wr_miss", 1'b0, 16'h0020, 16'h1234, 5, 1'b0, 16'h0000);

        // HALT suppresses the access
        bus.mem_read_in = 1'b1; bus.halt_in = 1'b1; bus.alu_result_in = 16'h0040;
        @(negedge clk);
        chk("halt_rd", bus.dmem_rd, 1'b0);
        chk("halt_stall", bus.mem_stall, 1'b0);
        @(posedge clk); #1;
        idle_inputs();
        chk("halt_acc", acc_cnt, m_acc);

        // done in IDLE without a launch is ignored
        bus.dmem_done = 1'b1; bus.dmem_hit = 1'b1; bus.dmem_rdata = 16'h5555;
        @(posedge clk); #1;
        idle_inputs();
        chk("stray_acc", acc_cnt, m_acc);
        chk("stray_hit", hit_cnt, m_hit);
        chk("stray_rdata", bus.mem_rdata, m_rdata);

        // 3. unaligned read
        bus.mem_read_in = 1'b1; bus.alu_result_in = 16'h0011; bus.dmem_done = 1'b1;
        @(negedge clk);
        chk("t3_rd", bus.dmem_rd, 1'b0);
        chk("t3_stall", bus.mem_stall, 1'b0);
        @(posedge clk); #1;
        idle_inputs();
        m_err = 1'b1;
        chk("t3_err", bus.mem_err, 1'b1);
        chk("t3_acc", acc_cnt, m_acc);
        do_access("t3_after", 1'b1, 16'h0012, 16'h0000, 2, 1'b1, 16'hA1A1);
        chk("t3_err_sticky", bus.mem_err, 1'b1);

        // 4. timeout: done never comes
        bus.mem_read_in = 1'b1; bus.alu_result_in = 16'h0050;
        for (int c = 0; c <= TMO; c++) begin
            @(negedge clk);
            chk($sformatf("t4_stall_c%0d", c), bus.mem_stall, (c < TMO) ? 1'b1 : 1'b0);
            @(posedge clk); #1;
        end
        idle_inputs();
        chk("t4_err", bus.mem_err, 1'b1);
        chk("t4_acc", acc_cnt, m_acc);
        chk("t4_rdata", bus.mem_rdata, m_rdata);

        // 5. back-to-back: read miss then write hit on the very next cycle
        do_access("t5_rd_miss", 1'b1, 16'h0030, 16'h0000, 3, 1'b0, 16'h5A5A);
        do_access("t5_wr_hit",  1'b0, 16'h0032, 16'h7777, 0, 1'b1, 16'h0000);

        // 6. reset during WAIT
        bus.mem_read_in = 1'b1; bus.alu_result_in = 16'h0060;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b0;
        idle_inputs();
        #1;
        chk("t6_stall", bus.mem_stall, 1'b0);
        chk("t6_addr",  bus.dmem_addr, 16'h0000);
        chk("t6_err",   bus.mem_err,   1'b0);
        chk("t6_acc",   acc_cnt,       4'h0);
        chk("t6_hit",   hit_cnt,       4'h0);
        chk("t6_rdata", bus.mem_rdata, 16'h0000);
        m_acc = 4'h0; m_hit = 4'h0; m_rdata = 16'h0000; m_err = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        do_access("t6_relaunch", 1'b1, 16'h0070, 16'h0000, 1, 1'b1, 16'hC0DE);

        // 7. counter saturation at 4 bits
        for (int i = 0; i < 20; i++) begin
            do_access($sformatf("t7_hit%0d", i), i[0], 16'(16'h0100 + 16'(2 * i)),
                      16'(i), 0, 1'b1, 16'(16'h9000 + 16'(i)));
        end
        chk("t7_acc_sat", acc_cnt, 4'hF);
        chk("t7_hit_sat", hit_cnt, 4'hF);
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
